// File: rtl/serial_pkg.sv
// Shared constants and state type for the serial byte link (transmitter and
// the matching receiver).
package serial_pkg;

  localparam int unsigned WORD_W = 8;
  localparam int unsigned DIV_W  = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: latches the period at word load and emits a registered
// one-cycle tick in the last cycle of every bit period while running.
module bit_tick_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic             stop,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             tick_nxt_c
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] lat_nxt;

  // Next counter value; the tick is registered from the counter's next value.
  always_comb begin
    cnt_nxt = div_cnt;
    lat_nxt = div_lat;
    if (load) begin
      cnt_nxt = div;
      lat_nxt = div;
    end else if (stop || !run) begin
      cnt_nxt = '0;
    end else if (div_cnt == '0) begin
      cnt_nxt = div_lat;
    end else begin
      cnt_nxt = div_cnt - DIV_W'(1);
    end
    tick_nxt_c = (load || (run && !stop)) && (cnt_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      div_cnt <= '0;
      div_lat <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= cnt_nxt;
      div_lat <= lat_nxt;
      tick    <= tick_nxt_c;
    end
  end

endmodule

// File: rtl/serial_byte_tx.sv
// Parallel-in, serial-out word transmitter, MSB first, with a one-word hold
// buffer so back-to-back words go out without a gap.
module serial_byte_tx
  import serial_pkg::*;
#(
  parameter int unsigned WORD_W = serial_pkg::WORD_W,
  parameter int unsigned DIV_W  = serial_pkg::DIV_W
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic [DIV_W-1:0]  DIV,
  input  logic [WORD_W-1:0] P_DATA_IN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              S_DATA_OUT,
  output logic              SH_EN,
  output logic              FRAME,
  output logic              WORD_DONE,
  output logic              BUSY
);

  localparam int unsigned CNT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  state_t            state;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] hold;
  logic              hold_full;
  logic [CNT_W-1:0]  bit_cnt;
  logic              frame;
  logic              word_done;
  logic              in_ready;
  logic              busy;
  logic              tick;
  logic              tick_nxt_c;

  logic              accept_c;
  logic              end_word_c;
  logic              load_direct_c;
  logic              load_hold_c;
  logic              load_c;
  logic              stop_c;
  logic              fill_c;
  logic              frame_nxt_c;
  logic              hold_full_nxt_c;
  logic [CNT_W-1:0]  bit_cnt_nxt_c;

  // A byte offered at the end-of-word edge with an empty hold goes straight
  // into the shifter, keeping the stream gap-free.
  always_comb begin
    accept_c        = IN_VALID && in_ready;
    end_word_c      = (state == SHIFT) && tick && (bit_cnt == '0);
    load_direct_c   = accept_c && ((state == IDLE) || (end_word_c && !hold_full));
    load_hold_c     = end_word_c && hold_full;
    load_c          = load_direct_c || load_hold_c;
    stop_c          = end_word_c && !load_c;
    fill_c          = accept_c && !load_direct_c;
    frame_nxt_c     = load_c || ((state == SHIFT) && !stop_c);
    hold_full_nxt_c = fill_c || (hold_full && !load_hold_c);
    bit_cnt_nxt_c   = bit_cnt;
    if (load_c) begin
      bit_cnt_nxt_c = LAST_BIT;
    end else if ((state == SHIFT) && tick && (bit_cnt != '0)) begin
      bit_cnt_nxt_c = bit_cnt - CNT_W'(1);
    end
  end

  bit_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk        (CLK),
    .clr_n      (CLR_N),
    .load       (load_c),
    .stop       (stop_c),
    .run        (state == SHIFT),
    .div        (DIV),
    .tick       (tick),
    .tick_nxt_c (tick_nxt_c)
  );

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      frame     <= 1'b0;
      word_done <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      state <= frame_nxt_c ? SHIFT : IDLE;
      if (load_c) begin
        shift_reg <= load_direct_c ? P_DATA_IN : hold;
      end else if ((state == SHIFT) && tick) begin
        shift_reg <= shift_reg << 1;
      end
      if (fill_c) begin
        hold <= P_DATA_IN;
      end
      hold_full <= hold_full_nxt_c;
      bit_cnt   <= bit_cnt_nxt_c;
      frame     <= frame_nxt_c;
      word_done <= tick_nxt_c && frame_nxt_c && (bit_cnt_nxt_c == '0);
      in_ready  <= !hold_full_nxt_c;
      busy      <= frame_nxt_c || hold_full_nxt_c;
    end
  end

  assign S_DATA_OUT = shift_reg[WORD_W-1];
  assign SH_EN      = tick;
  assign FRAME      = frame;
  assign WORD_DONE  = word_done;
  assign IN_READY   = in_ready;
  assign BUSY       = busy;

endmodule

// File: tb/tb_serial_byte_tx.sv
// Scoreboard bench for serial_byte_tx: each accepted byte queues its expected
// bits and bit periods; a negedge monitor checks every shift strobe.
module tb_serial_byte_tx;

  logic       CLK;
  logic       CLR_N;
  logic [7:0] DIV;
  logic [7:0] P_DATA_IN;
  logic       IN_VALID;
  logic       IN_READY;
  logic       S_DATA_OUT;
  logic       SH_EN;
  logic       FRAME;
  logic       WORD_DONE;
  logic       BUSY;

  typedef struct {
    bit          b;
    bit          last;
    int unsigned period;
  } exp_t;

  exp_t        sb[$];
  int unsigned pushes = 0;
  int          total  = 0;
  int          bad    = 0;

  int          cnt = 0;
  bit          chk_next = 0;
  int          q_at_done = 0;
  int unsigned push_at_done = 0;

  serial_byte_tx dut (
    .CLK        (CLK),
    .CLR_N      (CLR_N),
    .DIV        (DIV),
    .P_DATA_IN  (P_DATA_IN),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .S_DATA_OUT (S_DATA_OUT),
    .SH_EN      (SH_EN),
    .FRAME      (FRAME),
    .WORD_DONE  (WORD_DONE),
    .BUSY       (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected bit per strobe, checks data, period, word end.
  always @(negedge CLK) begin
    exp_t e;
    if (!CLR_N) begin
      cnt      = 0;
      chk_next = 0;
    end else begin
      if (FRAME) cnt++;
      if (chk_next) begin
        chk_next = 0;
        if (q_at_done > 0)
          chk("frame_contiguous", 32'(FRAME), 32'd1);
        else if (pushes == push_at_done)
          chk("frame_end", 32'({FRAME, S_DATA_OUT}), 32'd0);
      end
      if (SH_EN) begin
        if (sb.size() == 0) begin
          chk("unexpected_sh_en", 32'(SH_EN), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("bit", 32'(S_DATA_OUT), 32'(e.b));
          chk("word_done", 32'(WORD_DONE), 32'(e.last));
          chk("period", 32'(cnt), 32'(e.period));
          cnt = 0;
          if (e.last) begin
            chk_next     = 1;
            q_at_done    = sb.size();
            push_at_done = pushes;
          end
        end
      end else if (WORD_DONE) begin
        chk("stray_word_done", 32'(WORD_DONE), 32'd0);
      end
      if (!FRAME)
        chk("idle_outputs", 32'({S_DATA_OUT, SH_EN, WORD_DONE}), 32'd0);
    end
  end

  // Offer a byte (caller sits at a negedge); div_at_load is the DIV that will
  // be in force when this byte enters the shifter.
  task automatic send(input logic [7:0] b, input int unsigned div_at_load);
    bit   was_empty;
    int   w;
    exp_t e;
    IN_VALID  = 1'b1;
    P_DATA_IN = b;
    w = 0;
    while (!IN_READY && w < 400) begin
      @(negedge CLK);
      w++;
    end
    if (!IN_READY) begin
      chk("ready_timeout", 32'(IN_READY), 32'd1);
      IN_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    was_empty = (sb.size() == 0);
    for (int i = 7; i >= 0; i--) begin
      e.b      = b[i];
      e.last   = (i == 0);
      e.period = div_at_load + 1;
      sb.push_back(e);
    end
    pushes++;
    @(negedge CLK);
    IN_VALID = 1'b0;
    if (was_empty)
      chk("load_start", 32'({FRAME, S_DATA_OUT, IN_READY, BUSY}), 32'({1'b1, b[7], 1'b1, 1'b1}));
    else
      chk("hold_full", 32'({IN_READY, BUSY}), 32'b01);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || FRAME) && w < 4000) begin
      @(negedge CLK);
      w++;
    end
    chk("drain_timeout", 32'(sb.size() == 0 && !FRAME), 32'd1);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int w;
    int unsigned d;
    int unsigned n;
    CLR_N     = 1'b0;
    IN_VALID  = 1'b0;
    DIV       = 8'd0;
    P_DATA_IN = 8'd0;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 32'({S_DATA_OUT, FRAME, SH_EN, WORD_DONE, BUSY, IN_READY}), 32'b000001);
    CLR_N = 1'b1;
    repeat (20) @(negedge CLK);
    chk("idle_ready", 32'({IN_READY, BUSY}), 32'b10);

    DIV = 8'd0; send(8'hA5, 0); drain();
    DIV = 8'd2; send(8'h81, 2); drain();
    DIV = 8'd1; send(8'h3C, 1); send(8'hC3, 1); drain();

    // Abort a word with reset after its third bit.
    DIV = 8'd3; send(8'hFF, 3);
    w = 0;
    while (sb.size() > 5 && w < 200) begin
      @(negedge CLK);
      w++;
    end
    chk("abort_point", 32'(sb.size()), 32'd5);
    @(posedge CLK);
    #1 CLR_N = 1'b0;
    sb.delete();
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_outputs", 32'({S_DATA_OUT, FRAME, IN_READY, BUSY, WORD_DONE}), 32'b00100);
    CLR_N = 1'b1;
    @(negedge CLK);
    send(8'h01, 3); drain();

    // DIV change mid-word only affects the next word.
    DIV = 8'd1; send(8'h55, 1);
    DIV = 8'd5; send(8'h0F, 5); drain();

    for (int it = 0; it < 30; it++) begin
      d   = $urandom_range(0, 3);
      DIV = 8'(d);
      n   = $urandom_range(1, 3);
      for (int k = 0; k < int'(n); k++) begin
        repeat ($urandom_range(0, 12)) @(negedge CLK);
        send(8'($urandom), d);
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
